ex_mdu: RTL and testbench

EX_MDU -- requirements
Module: ex_mdu

---
 rtl/ex_mdu_pkg.sv | 55 +++++
 rtl/mdu_divider.sv | 95 +++++++++
 rtl/ex_mdu.sv | 150 +++++++++++++++
 tb/tb_ex_mdu.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ex_mdu_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: aluop codes, register
// address width and FSM states. Optional build macro: MDU_FAST_MUL_EN.
package ex_mdu_pkg;

    localparam int ALUOP_W   = 8;
    localparam int REGADDR_W = 5;

    localparam logic [REGADDR_W-1:0] NOP_REG_ADDR = 5'd0;

    // M-extension ops sit in their own block next to the base ALU ops
    localparam logic [ALUOP_W-1:0] EX_MUL    = 8'h20;
    localparam logic [ALUOP_W-1:0] EX_MULH   = 8'h21;
    localparam logic [ALUOP_W-1:0] EX_MULHSU = 8'h22;
    localparam logic [ALUOP_W-1:0] EX_MULHU  = 8'h23;
    localparam logic [ALUOP_W-1:0] EX_DIV    = 8'h24;
    localparam logic [ALUOP_W-1:0] EX_DIVU   = 8'h25;
    localparam logic [ALUOP_W-1:0] EX_REM    = 8'h26;
    localparam logic [ALUOP_W-1:0] EX_REMU   = 8'h27;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_t;

    function automatic logic is_div_op(input logic [ALUOP_W-1:0] op);
        case (op)
            EX_DIV, EX_DIVU, EX_REM, EX_REMU: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_div(input logic [ALUOP_W-1:0] op);
        case (op)
            EX_DIV, EX_REM: return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

    function automatic logic mul_r1_signed(input logic [ALUOP_W-1:0] op);
        case (op)
            EX_MULH, EX_MULHSU: return 1'b1;
            default:            return 1'b0;
        endcase
    endfunction

    function automatic logic mul_r2_signed(input logic [ALUOP_W-1:0] op);
        case (op)
            EX_MULH: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Radix-2 restoring divider on operand magnitudes with sign fix-up; divide-by-zero
// and signed overflow finish in the first cycle without iterating.
module mdu_divider #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_kill,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    input  logic            i_signed,
    output logic [XLEN-1:0] o_quotient,
    output logic [XLEN-1:0] o_remainder,
    output logic            o_done
);

    localparam logic [XLEN-1:0] ONE_W  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] MIN_W  = {1'b1, {(XLEN-1){1'b0}}};

    logic             r_busy, r_special, r_q_neg, r_r_neg;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_rem, r_quo, r_dvsr, r_sp_quo, r_sp_rem;

    logic             w_a_neg, w_b_neg, w_div0, w_ovf, w_ge;
    logic [XLEN-1:0]  w_a_mag, w_b_mag, w_rem_nxt, w_quo_nxt;
    logic [XLEN:0]    w_trial, w_diff;

    assign w_a_neg = i_signed & i_dividend[XLEN-1];
    assign w_b_neg = i_signed & i_divisor[XLEN-1];
    assign w_a_mag = w_a_neg ? (~i_dividend + ONE_W) : i_dividend;
    assign w_b_mag = w_b_neg ? (~i_divisor + ONE_W) : i_divisor;
    assign w_div0  = (i_divisor == {XLEN{1'b0}});
    assign w_ovf   = i_signed & (i_dividend == MIN_W) & (i_divisor == {XLEN{1'b1}});

    // Remainder never exceeds the divisor, so a borrow out of bit XLEN means "restore"
    assign w_trial   = {r_rem, r_quo[XLEN-1]};
    assign w_diff    = w_trial - {1'b0, r_dvsr};
    assign w_ge      = ~w_diff[XLEN];
    assign w_rem_nxt = w_ge ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];
    assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};

    assign o_done = r_busy & (r_special | (r_cnt == CNT_W'(XLEN - 1)));

    // Final results, valid while o_done is high
    always_comb begin
        o_quotient  = {XLEN{1'b0}};
        o_remainder = {XLEN{1'b0}};
        if (r_special) begin
            o_quotient  = r_sp_quo;
            o_remainder = r_sp_rem;
        end else begin
            o_quotient  = r_q_neg ? (~w_quo_nxt + ONE_W) : w_quo_nxt;
            o_remainder = r_r_neg ? (~w_rem_nxt + ONE_W) : w_rem_nxt;
        end
    end

    // Divider iteration state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy    <= 1'b0;
            r_special <= 1'b0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_cnt     <= {CNT_W{1'b0}};
            r_rem     <= {XLEN{1'b0}};
            r_quo     <= {XLEN{1'b0}};
            r_dvsr    <= {XLEN{1'b0}};
            r_sp_quo  <= {XLEN{1'b0}};
            r_sp_rem  <= {XLEN{1'b0}};
        end else if (i_kill) begin
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_busy    <= 1'b1;
            r_special <= w_div0 | w_ovf;
            r_q_neg   <= w_a_neg ^ w_b_neg;
            r_r_neg   <= w_a_neg;
            r_cnt     <= {CNT_W{1'b0}};
            r_rem     <= {XLEN{1'b0}};
            r_quo     <= w_a_mag;
            r_dvsr    <= w_b_mag;
            r_sp_quo  <= w_div0 ? {XLEN{1'b1}} : i_dividend;
            r_sp_rem  <= w_div0 ? i_dividend : {XLEN{1'b0}};
        end else if (r_busy) begin
            r_busy <= ~o_done;
            r_cnt  <= r_cnt + CNT_W'(1);
            r_rem  <= w_rem_nxt;
            r_quo  <= w_quo_nxt;
        end else begin
            r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/ex_mdu.sv
// EX-stage M-extension unit: iterative shift-add multiplier (single-cycle product
// when MDU_FAST_MUL_EN is defined) plus restoring divider, one writeback per op.
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic [ALUOP_W-1:0]   aluop_i,
    input  logic [XLEN-1:0]      r1_i,
    input  logic [XLEN-1:0]      r2_i,
    input  logic [REGADDR_W-1:0] w_addr_i,
    input  logic                 flush_i,
    output logic                 stall_o,
    output logic                 busy_o,
    output logic                 w_req_o,
    output logic [REGADDR_W-1:0] w_addr_o,
    output logic [XLEN-1:0]      w_data_o
);

    localparam logic [XLEN-1:0]   ONE_W  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE_2W = {{(2*XLEN-1){1'b0}}, 1'b1};

    mdu_state_t           r_state, w_state_nxt;
    logic [ALUOP_W-1:0]   r_op;
    logic [REGADDR_W-1:0] r_waddr;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*XLEN-1:0]    r_mcand, r_prod;
    logic [XLEN-1:0]      r_mplier, r_result;
    logic                 r_mul_neg;

    logic                 w_accept, w_r1_neg, w_r2_neg, w_mul_last, w_in_done;
    logic                 w_div_start, w_div_done;
    logic [XLEN-1:0]      w_r1_mag, w_r2_mag, w_div_quo, w_div_rem, w_result;
    logic [2*XLEN-1:0]    w_prod_nxt, w_mul_mag, w_mul_prod;

    assign w_accept    = (r_state == ST_IDLE) & valid_i & ~flush_i;
    assign w_div_start = w_accept & is_div_op(aluop_i);

    assign w_r1_neg = mul_r1_signed(aluop_i) & r1_i[XLEN-1];
    assign w_r2_neg = mul_r2_signed(aluop_i) & r2_i[XLEN-1];
    assign w_r1_mag = w_r1_neg ? (~r1_i + ONE_W) : r1_i;
    assign w_r2_mag = w_r2_neg ? (~r2_i + ONE_W) : r2_i;

    assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : {(2*XLEN){1'b0}});

`ifdef MDU_FAST_MUL_EN
    assign w_mul_last = 1'b1;
    assign w_mul_mag  = {{XLEN{1'b0}}, r_mcand[XLEN-1:0]} * {{XLEN{1'b0}}, r_mplier};
`else
    assign w_mul_last = (r_cnt == CNT_W'(XLEN - 1));
    assign w_mul_mag  = w_prod_nxt;
`endif

    assign w_mul_prod = r_mul_neg ? (~w_mul_mag + ONE_2W) : w_mul_mag;

    mdu_divider #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_divider (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_div_start),
        .i_kill      (flush_i),
        .i_dividend  (r1_i),
        .i_divisor   (r2_i),
        .i_signed    (is_signed_div(aluop_i)),
        .o_quotient  (w_div_quo),
        .o_remainder (w_div_rem),
        .o_done      (w_div_done)
    );

    // Result selection for the op being completed
    always_comb begin
        w_result = {XLEN{1'b0}};
        case (r_op)
            EX_MUL:                       w_result = w_mul_prod[XLEN-1:0];
            EX_MULH, EX_MULHSU, EX_MULHU: w_result = w_mul_prod[2*XLEN-1:XLEN];
            EX_DIV, EX_DIVU:              w_result = w_div_quo;
            EX_REM, EX_REMU:              w_result = w_div_rem;
            default:                      w_result = {XLEN{1'b0}};
        endcase
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = w_accept ? (is_div_op(aluop_i) ? ST_DIV : ST_MUL) : ST_IDLE;
                ST_MUL:  w_state_nxt = w_mul_last ? ST_DONE : ST_MUL;
                ST_DIV:  w_state_nxt = w_div_done ? ST_DONE : ST_DIV;
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, operand latches and multiplier accumulator
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_op      <= {ALUOP_W{1'b0}};
            r_waddr   <= NOP_REG_ADDR;
            r_cnt     <= {CNT_W{1'b0}};
            r_mcand   <= {(2*XLEN){1'b0}};
            r_prod    <= {(2*XLEN){1'b0}};
            r_mplier  <= {XLEN{1'b0}};
            r_result  <= {XLEN{1'b0}};
            r_mul_neg <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op      <= aluop_i;
                r_waddr   <= w_addr_i;
                r_cnt     <= {CNT_W{1'b0}};
                r_mcand   <= {{XLEN{1'b0}}, w_r1_mag};
                r_prod    <= {(2*XLEN){1'b0}};
                r_mplier  <= w_r2_mag;
                r_mul_neg <= w_r1_neg ^ w_r2_neg;
            end else if (r_state == ST_MUL) begin
                r_cnt    <= r_cnt + CNT_W'(1);
                r_mcand  <= {r_mcand[2*XLEN-2:0], 1'b0};
                r_prod   <= w_prod_nxt;
                r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
            end else begin
                r_cnt <= r_cnt;
            end
            if (w_state_nxt == ST_DONE) begin
                r_result <= w_result;
            end else begin
                r_result <= r_result;
            end
        end
    end

    // A flush arriving during DONE suppresses the write in that same cycle
    assign w_in_done = (r_state == ST_DONE) & ~flush_i;
    assign w_req_o   = w_in_done;
    assign w_addr_o  = w_in_done ? r_waddr : NOP_REG_ADDR;
    assign w_data_o  = w_in_done ? r_result : {XLEN{1'b0}};
    assign busy_o    = (r_state != ST_IDLE);
    assign stall_o   = ((r_state == ST_IDLE) & valid_i) | (r_state == ST_MUL) | (r_state == ST_DIV);

endmodule

// File: tb/tb_ex_mdu.sv
// Directed self-checking bench for ex_mdu (default XLEN=32).
module tb_ex_mdu;
    import ex_mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_i = 1'b0;
    logic [7:0]  aluop_i = 8'h00;
    logic [31:0] r1_i = 32'h0;
    logic [31:0] r2_i = 32'h0;
    logic [4:0]  w_addr_i = 5'd0;
    logic        flush_i = 1'b0;
    logic        stall_o, busy_o, w_req_o;
    logic [4:0]  w_addr_o;
    logic [31:0] w_data_o;

    int n_checks = 0;
    int n_errors = 0;

    ex_mdu dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .aluop_i  (aluop_i),
        .r1_i     (r1_i),
        .r2_i     (r2_i),
        .w_addr_i (w_addr_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .w_req_o  (w_req_o),
        .w_addr_o (w_addr_o),
        .w_data_o (w_data_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one op, count edges from acceptance to the write, check result and one-cycle w_req
    task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_data, input int exp_lat);
        int lat;
        @(negedge clk);
        valid_i = 1'b1; aluop_i = op; r1_i = a; r2_i = b; w_addr_i = rd;
        #1;
        check({tag, ".stall_idle"}, {31'd0, stall_o}, 32'd1);
        @(posedge clk); #1;
        valid_i = 1'b0;
        lat = 1;
        while (!w_req_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".data"}, w_data_o, exp_data);
        check({tag, ".addr"}, {27'd0, w_addr_o}, {27'd0, rd});
        check({tag, ".stall_done"}, {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        check({tag, ".req_once"}, {31'd0, w_req_o}, 32'd0);
        check({tag, ".idle"}, {31'd0, busy_o}, 32'd0);
    endtask

    int seen;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst.req", {31'd0, w_req_o}, 32'd0);
        check("rst.busy", {31'd0, busy_o}, 32'd0);
        check("rst.stall", {31'd0, stall_o}, 32'd0);
        check("rst.data", w_data_o, 32'd0);
        check("rst.addr", {27'd0, w_addr_o}, 32'd0);
        rst = 1'b1;

        run_op("mul_7_m3",  EX_MUL,    32'd7,        32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, MUL_LAT);
        run_op("mulhu_ff",  EX_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, MUL_LAT);
        run_op("mulh_ff",   EX_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_0000, MUL_LAT);
        run_op("mulhsu_ff", EX_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF, MUL_LAT);
        run_op("mul_ff",    EX_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'h0000_0001, MUL_LAT);
        run_op("div_m7_2",  EX_DIV,    32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, DIV_LAT);
        run_op("rem_m7_2",  EX_REM,    32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF, DIV_LAT);
        run_op("divu_100",  EX_DIVU,   32'd100,       32'd7,         5'd9,  32'd14,        DIV_LAT);
        run_op("remu_100",  EX_REMU,   32'd100,       32'd7,         5'd10, 32'd2,         DIV_LAT);
        run_op("divu_big",  EX_DIVU,   32'hFFFF_FFFF, 32'h10,        5'd11, 32'h0FFF_FFFF, DIV_LAT);
        run_op("divu_z",    EX_DIVU,   32'd5,         32'd0,         5'd12, 32'hFFFF_FFFF, 2);
        run_op("remu_z",    EX_REMU,   32'd5,         32'd0,         5'd13, 32'd5,         2);
        run_op("div_mz",    EX_DIV,    32'hFFFF_FFFB, 32'd0,         5'd14, 32'hFFFF_FFFF, 2);
        run_op("rem_mz",    EX_REM,    32'hFFFF_FFFB, 32'd0,         5'd15, 32'hFFFF_FFFB, 2);
        run_op("div_ovf",   EX_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 2);
        run_op("rem_ovf",   EX_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000, 2);

        // Flush at iteration 10 of a DIV
        @(negedge clk);
        valid_i = 1'b1; aluop_i = EX_DIV; r1_i = 32'd1000; r2_i = 32'd3; w_addr_i = 5'd20;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        check("flush.busy", {31'd0, busy_o}, 32'd0);
        check("flush.stall", {31'd0, stall_o}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (w_req_o) seen++;
        end
        check("flush.no_write", seen, 0);

        // Reset in the middle of a MUL
        @(negedge clk);
        valid_i = 1'b1; aluop_i = EX_MUL; r1_i = 32'd9; r2_i = 32'd9; w_addr_i = 5'd21;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("rstmid.busy", {31'd0, busy_o}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (w_req_o) seen++;
        end
        check("rstmid.no_write", seen, 0);

        // Flush during DONE suppresses the write already in progress
        @(negedge clk);
        valid_i = 1'b1; aluop_i = EX_DIVU; r1_i = 32'd5; r2_i = 32'd0; w_addr_i = 5'd22;
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(posedge clk); #1;
        check("flushdone.busy", {31'd0, busy_o}, 32'd1);
        flush_i = 1'b1;
        #1;
        check("flushdone.req", {31'd0, w_req_o}, 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        check("flushdone.idle", {31'd0, busy_o}, 32'd0);

        // The unit recovers and completes a normal op afterwards
        run_op("post_div", EX_DIVU, 32'd81, 32'd9, 5'd23, 32'd9, DIV_LAT);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
